// File: rtl/fadd_pipe.sv
// fadd_pipe: three-stage pipelined binary32 adder, y = a + b.
//
// Arithmetic behaviour: truncation toward zero, hidden one always set
// (including e=0), flush-to-zero, saturation to infinity, and an overflow
// flag. There is no special handling for denormals or NaN.
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   in_valid   operand pair a/b is presented
//   in_ready   stage 1 can accept this cycle (no path from in_valid)
//   a, b       binary32 operands
//   out_valid  y/ovf hold a result
//   out_ready  consumer accepts the result this cycle
//   y          registered sum
//   ovf        registered overflow flag (finite inputs produced infinity)
//
// Pipeline: stage 1 compare/align, stage 2 add/leading-zero count,
// stage 3 normalize/pack into the output register.
module fadd_pipe (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  // Stage 1 registers (aligned operands)
  logic        v1_q,      v1_d;
  logic        s1_l_s_q,  s1_l_s_d;
  logic [7:0]  s1_l_e_q,  s1_l_e_d;
  logic [23:0] s1_l_m_q,  s1_l_m_d;
  logic [23:0] s1_s_m_q,  s1_s_m_d;
  logic        s1_sub_q,  s1_sub_d;
  logic        s1_inf_q,  s1_inf_d;

  // Stage 2 registers (raw sum and its leading-zero count)
  logic        v2_q,      v2_d;
  logic        s2_l_s_q,  s2_l_s_d;
  logic [7:0]  s2_l_e_q,  s2_l_e_d;
  logic [24:0] s2_m_raw_q, s2_m_raw_d;
  logic [4:0]  s2_lz_q,   s2_lz_d;
  logic        s2_inf_q,  s2_inf_d;

  // Stage 3 registers (the outputs)
  logic        out_valid_q, out_valid_d;
  logic [31:0] y_q,       y_d;
  logic        ovf_q,     ovf_d;

  // Handshake: each stage moves when it is empty or its successor moves.
  // in_ready is built only from registered valids and out_ready.
  logic adv1, adv2, adv3;
  assign adv3     = !out_valid_q || out_ready;
  assign adv2     = !v2_q || adv3;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

  // Stage 1 datapath: pick the larger magnitude operand and align the
  // smaller one. Ties on exponent and mantissa select b as "larger".
  logic [7:0]  a_e, b_e, l_e, s_e, exp_diff;
  logic [23:0] a_m, b_m, l_m, s_m;
  logic        a_larger, l_s;
  logic [4:0]  shift_amt;

  always_comb begin
    a_e       = a[30:23];
    b_e       = b[30:23];
    a_m       = {1'b1, a[22:0]};
    b_m       = {1'b1, b[22:0]};
    a_larger  = (a_e > b_e) || ((a_e == b_e) && (a_m > b_m));
    l_s       = a_larger ? a[31] : b[31];
    l_e       = a_larger ? a_e : b_e;
    s_e       = a_larger ? b_e : a_e;
    l_m       = a_larger ? a_m : b_m;
    s_m       = a_larger ? b_m : a_m;
    exp_diff  = l_e - s_e;
    // A shift of 24 already clears a 24-bit mantissa, so clamp there.
    shift_amt = (exp_diff > 8'd24) ? 5'd24 : exp_diff[4:0];
  end

  // Stage 1 next-state: load on acceptance, otherwise hold.
  always_comb begin
    v1_d     = v1_q;
    s1_l_s_d = s1_l_s_q;
    s1_l_e_d = s1_l_e_q;
    s1_l_m_d = s1_l_m_q;
    s1_s_m_d = s1_s_m_q;
    s1_sub_d = s1_sub_q;
    s1_inf_d = s1_inf_q;
    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        s1_l_s_d = l_s;
        s1_l_e_d = l_e;
        s1_l_m_d = l_m;
        s1_s_m_d = s_m >> shift_amt;
        s1_sub_d = a[31] ^ b[31];
        s1_inf_d = (a_e == 8'hFF) || (b_e == 8'hFF);
      end
    end
  end

  // Stage 2 datapath: add or subtract magnitudes. The larger operand was
  // chosen in stage 1, so the subtraction never goes negative.
  logic [24:0] m_raw_calc;
  logic [4:0]  lz_calc;

  always_comb begin
    m_raw_calc = s1_sub_q ? ({1'b0, s1_l_m_q} - {1'b0, s1_s_m_q})
                          : ({1'b0, s1_l_m_q} + {1'b0, s1_s_m_q});
    // Highest set bit wins because later iterations overwrite earlier ones.
    lz_calc = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (m_raw_calc[i]) lz_calc = 5'(23 - i);
    end
  end

  // Stage 2 next-state.
  always_comb begin
    v2_d       = v2_q;
    s2_l_s_d   = s2_l_s_q;
    s2_l_e_d   = s2_l_e_q;
    s2_m_raw_d = s2_m_raw_q;
    s2_lz_d    = s2_lz_q;
    s2_inf_d   = s2_inf_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_l_s_d   = s1_l_s_q;
        s2_l_e_d   = s1_l_e_q;
        s2_m_raw_d = m_raw_calc;
        s2_lz_d    = lz_calc;
        s2_inf_d   = s1_inf_q;
      end
    end
  end

  // Stage 3 datapath: normalize and pack. A carry shifts right by one and
  // bumps the exponent (saturating at 255); otherwise shift left by the
  // leading-zero count and flush to zero on exponent underflow.
  logic [8:0]  e_norm;
  logic [23:0] m_norm;
  logic [7:0]  res_e;
  logic [22:0] res_m;
  logic [31:0] res_y;
  logic        res_ovf;

  always_comb begin
    e_norm = {1'b0, s2_l_e_q} - {4'b0, s2_lz_q};
    m_norm = s2_m_raw_q[23:0] << s2_lz_q;
    if (s2_m_raw_q[24]) begin
      res_m = s2_m_raw_q[23:1];
      res_e = (s2_l_e_q == 8'hFF) ? 8'hFF : s2_l_e_q + 8'd1;
    end else begin
      res_m = m_norm[22:0];
      res_e = e_norm[8] ? 8'd0 : e_norm[7:0];
    end

    if (s2_m_raw_q == 25'd0)   res_y = 32'h0000_0000;
    else if (res_e == 8'd0)    res_y = {s2_l_s_q, 31'b0};
    else if (res_e == 8'hFF)   res_y = {s2_l_s_q, 8'hFF, 23'b0};
    else                       res_y = {s2_l_s_q, res_e, res_m};

    res_ovf = !s2_inf_q && (res_e == 8'hFF);
  end

  // Stage 3 next-state: the output register only changes when it advances,
  // which keeps y/ovf stable under back-pressure.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    if (adv3) begin
      out_valid_d = v2_q;
      if (v2_q) begin
        y_d   = res_y;
        ovf_d = res_ovf;
      end
    end
  end

  // All pipeline state; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1_q        <= 1'b0;
      s1_l_s_q    <= 1'b0;
      s1_l_e_q    <= 8'd0;
      s1_l_m_q    <= 24'd0;
      s1_s_m_q    <= 24'd0;
      s1_sub_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      v2_q        <= 1'b0;
      s2_l_s_q    <= 1'b0;
      s2_l_e_q    <= 8'd0;
      s2_m_raw_q  <= 25'd0;
      s2_lz_q     <= 5'd0;
      s2_inf_q    <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= 32'd0;
      ovf_q       <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      s1_l_s_q    <= s1_l_s_d;
      s1_l_e_q    <= s1_l_e_d;
      s1_l_m_q    <= s1_l_m_d;
      s1_s_m_q    <= s1_s_m_d;
      s1_sub_q    <= s1_sub_d;
      s1_inf_q    <= s1_inf_d;
      v2_q        <= v2_d;
      s2_l_s_q    <= s2_l_s_d;
      s2_l_e_q    <= s2_l_e_d;
      s2_m_raw_q  <= s2_m_raw_d;
      s2_lz_q     <= s2_lz_d;
      s2_inf_q    <= s2_inf_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// tb_fadd_pipe: directed self-checking bench for fadd_pipe.
// Drives inputs on the falling edge and samples outputs there, away from
// the rising edge where the DUT updates.
module tb_fadd_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  fadd_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Truncating reference: aligns, adds magnitudes, then normalizes one bit
  // at a time. Returns {ovf, y}.
  function automatic logic [32:0] ref_add(input logic [31:0] fa, input logic [31:0] fb);
    int ae, be, am, bm, le, se, lm, sm, d, sum, e;
    logic ls, a_big, of;
    logic [31:0] r;
    ae = int'(fa[30:23]);
    be = int'(fb[30:23]);
    am = int'({1'b1, fa[22:0]});
    bm = int'({1'b1, fb[22:0]});
    a_big = (ae > be) || (ae == be && am > bm);
    le = a_big ? ae : be;
    se = a_big ? be : ae;
    lm = a_big ? am : bm;
    sm = a_big ? bm : am;
    ls = a_big ? fa[31] : fb[31];
    d = le - se;
    if (d > 24) d = 24;
    sm = sm >> d;
    sum = (fa[31] ^ fb[31]) ? lm - sm : lm + sm;
    if (sum == 0) return 33'd0;
    if (sum >= 32'h0100_0000) begin
      sum = sum >> 1;
      e = le + 1;
      if (e > 255) e = 255;
    end else begin
      e = le;
      while (sum < 32'h0080_0000) begin
        sum = sum << 1;
        e = e - 1;
      end
      if (e < 0) e = 0;
    end
    if (e == 0)        r = {ls, 31'b0};
    else if (e >= 255) r = {ls, 8'hFF, 23'b0};
    else               r = {ls, e[7:0], sum[22:0]};
    of = (ae != 255) && (be != 255) && (e == 255);
    return {of, r};
  endfunction

  // Drive one operation into an empty pipeline with out_ready high and wait
  // for its result. lat counts rising edges from the accepting edge to the
  // edge that raised out_valid; it reaches 10 if the result never shows.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output logic [31:0] ry, output logic rovf, output int lat);
    @(negedge clk);
    a = ia;
    b = ib;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    ry   = y;
    rovf = ovf;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = 32'd0;
    b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (y !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_y: got %h expected 00000000", y); end
    n_cmp++;
    if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    rstn = 1'b1;
  endtask

  // Directed arithmetic vectors, each checked for value, flag and latency.
  task automatic test_basic();
    logic [31:0] va [6] = '{32'h3F80_0000, 32'h4000_0000, 32'h3FC0_0000,
                            32'h3F80_0000, 32'h7F7F_FFFF, 32'h7F80_0000};
    logic [31:0] vb [6] = '{32'h4000_0000, 32'hBF80_0000, 32'hBFC0_0000,
                            32'h3380_0000, 32'h7F7F_FFFF, 32'h3F80_0000};
    logic [31:0] ve [6] = '{32'h4040_0000, 32'h3F80_0000, 32'h0000_0000,
                            32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000};
    logic        vo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ry;
    logic        rovf;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], ry, rovf, lat);
      n_cmp++;
      if (lat !== 3) begin n_fail++; $display("[TB] FAIL latency[%0d]: got %0d expected 3", i, lat); end
      n_cmp++;
      if (ry !== ve[i]) begin n_fail++; $display("[TB] FAIL sum[%0d] %h+%h: got %h expected %h", i, va[i], vb[i], ry, ve[i]); end
      n_cmp++;
      if (rovf !== vo[i]) begin n_fail++; $display("[TB] FAIL ovf[%0d]: got %b expected %b", i, rovf, vo[i]); end
    end
  endtask

  // Eight operations streamed with a fixed irregular out_ready pattern.
  task automatic test_back_to_back();
    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic [32:0] exp_q [$];
    logic [32:0] exp_v;
    logic [15:0] rdy_pat = 16'b1011_0010_1110_0100;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_y = 32'd0;
    logic        prev_ovf = 1'b0;
    logic        in_fire, out_fire, exp_ready;
    int sent = 0, got = 0, occ = 0, cyc = 0;
    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
      // Close exponents on odd entries so cancellation paths get exercised.
      if (i % 2 == 1) sb[i][30:23] = sa[i][30:23] + 8'(i % 3);
    end
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || y !== prev_y || ovf !== prev_ovf) begin
          n_fail++;
          $display("[TB] FAIL stall_stable: got v=%b y=%h o=%b expected v=1 y=%h o=%b",
                   out_valid, y, ovf, prev_y, prev_ovf);
        end
      end
      out_ready = rdy_pat[cyc % 16];
      in_valid  = (sent < 8);
      a = sa[sent % 8];
      b = sb[sent % 8];
      #1;
      exp_ready = !(occ == 3 && !out_ready);
      n_cmp++;
      if (in_ready !== exp_ready) begin
        n_fail++;
        $display("[TB] FAIL stream_in_ready: got %b expected %b (occ %0d)", in_ready, exp_ready, occ);
      end
      out_fire = out_valid && out_ready;
      in_fire  = in_valid && in_ready;
      if (out_fire) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL stream_extra: got result %h expected none", y);
        end else begin
          exp_v = exp_q.pop_front();
          if ({ovf, y} !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL stream_result[%0d]: got y=%h ovf=%b expected y=%h ovf=%b",
                     got, y, ovf, exp_v[31:0], exp_v[32]);
          end
        end
        got++;
      end
      if (in_fire) begin
        exp_q.push_back(ref_add(a, b));
        sent++;
      end
      occ = occ + (in_fire ? 1 : 0) - (out_fire ? 1 : 0);
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
      prev_ovf   = ovf;
      @(posedge clk);
      cyc++;
    end
    n_cmp++;
    if (got !== 8) begin n_fail++; $display("[TB] FAIL stream_count: got %0d results expected 8", got); end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // Fill the pipeline against a blocked consumer, then release it.
  task automatic test_stall();
    logic [31:0] ta [4] = '{32'h3F80_0000, 32'h4040_0000, 32'h4080_0000, 32'h4120_0000};
    logic [31:0] tb [4] = '{32'h3F80_0000, 32'h3F80_0000, 32'hC000_0000, 32'h3F80_0000};
    logic [31:0] te [4] = '{32'h4000_0000, 32'h4080_0000, 32'h4000_0000, 32'h4130_0000};
    int acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      a = ta[acc];
      b = tb[acc];
      #1;
      if (in_ready) acc++;
      @(posedge clk);
    end
    n_cmp++;
    if (acc !== 3) begin n_fail++; $display("[TB] FAIL stall_accepted: got %0d expected 3", acc); end
    @(negedge clk);
    a = ta[3];
    b = tb[3];
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_in_ready: got %b expected 0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b1 || y !== te[0]) begin
      n_fail++;
      $display("[TB] FAIL stall_hold: got v=%b y=%h expected v=1 y=%h", out_valid, y, te[0]);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || y !== te[k]) begin
        n_fail++;
        $display("[TB] FAIL release_result[%0d]: got v=%b y=%h expected v=1 y=%h", k, out_valid, y, te[k]);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL release_drained: got %b expected 0", out_valid); end
  endtask

  // Reset with two operations in flight; nothing may emerge afterwards.
  task automatic test_reset_inflight();
    logic [31:0] ry;
    logic        rovf;
    int          lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 32'h4000_0000;
    b = 32'h4000_0000;
    @(posedge clk);
    @(negedge clk);
    a = 32'h4040_0000;
    b = 32'h3F80_0000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rstn     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flight_out_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (y !== 32'd0) begin n_fail++; $display("[TB] FAIL flight_y: got %h expected 00000000", y); end
    n_cmp++;
    if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL flight_ovf: got %b expected 0", ovf); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flight_in_ready: got %b expected 1", in_ready); end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flight_stale[%0d]: got %b expected 0", k, out_valid); end
    end
    run_op(32'h3F80_0000, 32'h4000_0000, ry, rovf, lat);
    n_cmp++;
    if (ry !== 32'h4040_0000 || lat !== 3) begin
      n_fail++;
      $display("[TB] FAIL after_reset_op: got y=%h lat=%0d expected y=40400000 lat=3", ry, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
